bgr_scan_ctrl: RTL and testbench

Parametrised sequencer driving the bandgap-reference array's startup pulses, select decoders and output switches. Replaces direct pad control of `porst`, `s_*`, `decoder_en_*` and `switch_en_*` with a command interface. Adds:
- break-before-make switching, with timed decoder settle;
- timed per-macro startup pulses;
- optional autonomous scan over all macros.

Sits between the user-project logic and the BGR/decoder/switch analog top.

---
 rtl/bgr_scan_pkg.sv | 23 ++
 rtl/bgr_scan_timer.sv | 26 ++
 rtl/bgr_scan_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_bgr_scan_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bgr_scan_pkg.sv
// Shared types and helpers for the BGR scan controller.
// Auto-scan is enabled by defining BGR_SCAN_AUTO_EN.
package bgr_scan_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BREAK  = 2'd1,
      SETTLE = 2'd2,
      PULSE  = 2'd3
   } state_t;

   localparam logic OP_SELECT  = 1'b0;
   localparam logic OP_STARTUP = 1'b1;

   // The timer is loaded with (cycles - 1), so the largest cycle count fits
   function automatic int cnt_w(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      return (m <= 1) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/bgr_scan_timer.sv
// Loadable down-counter with a zero flag, shared by all timed states.
module bgr_scan_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic [W-1:0] i_val,
   output logic         o_zero
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_val;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/bgr_scan_ctrl.sv
// Break-before-make select/switch and startup-pulse sequencer for the BGR array.
// Optional autonomous scan on channel 0 when BGR_SCAN_AUTO_EN is defined.
module bgr_scan_ctrl
   import bgr_scan_pkg::*;
#(
   parameter int N_BGR      = 32,
   parameter int NUM_CH     = 3,
   parameter int BREAK_CYC  = 4,
   parameter int SETTLE_CYC = 8,
   parameter int PORST_CYC  = 16,
   parameter int DWELL_CYC  = 1024,
   localparam int SEL_W     = $clog2(N_BGR),
   localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_op,
   input  logic [CH_W-1:0]         cmd_ch,
   input  logic [SEL_W-1:0]        cmd_idx,
   output logic                    done,
   output logic                    err,
   output logic [N_BGR-1:0]        porst,
   output logic [NUM_CH*SEL_W-1:0] s_sel,
   output logic [NUM_CH-1:0]       decoder_en,
   output logic [NUM_CH-1:0]       switch_en,
`ifdef BGR_SCAN_AUTO_EN
   input  logic                    auto_en,
`endif
   output logic                    busy
);

   localparam int CW = cnt_w(BREAK_CYC, SETTLE_CYC, PORST_CYC);
   localparam logic [SEL_W:0] NB = (SEL_W+1)'(N_BGR);
   localparam logic [CH_W:0]  NC = (CH_W+1)'(NUM_CH);

   state_t r_state, w_state_nxt;
   logic [CH_W-1:0]         r_ch;
   logic [SEL_W-1:0]        r_idx;
   logic [N_BGR-1:0]        r_porst, w_porst_nxt;
   logic [NUM_CH*SEL_W-1:0] r_sel, w_sel_nxt;
   logic [NUM_CH-1:0]       r_dec, w_dec_nxt;
   logic [NUM_CH-1:0]       r_sw, w_sw_nxt;
   logic                    r_done, w_done_nxt;
   logic                    r_err, w_err_nxt;
   logic                    w_load, w_zero, w_lat;
   logic [CW-1:0]           w_load_val;
   logic                    w_auto, w_go, w_go_op, w_bad;
   logic [CH_W-1:0]         w_go_ch;
   logic [SEL_W-1:0]        w_go_idx, w_auto_idx;

`ifdef BGR_SCAN_AUTO_EN
   localparam int IW = $clog2(DWELL_CYC + 1);
   logic [IW-1:0]    r_idle;
   logic [SEL_W-1:0] w_sel0;

   assign w_sel0     = r_sel[SEL_W-1:0];
   assign w_auto_idx = (w_sel0 == SEL_W'(N_BGR - 1)) ? '0 : w_sel0 + 1'b1;
   assign w_auto     = (r_state == IDLE) && auto_en && !cmd_valid &&
                       (r_idle == IW'(DWELL_CYC - 1));

   // External commands and busy time both restart the dwell
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idle <= '0;
      end else if (r_state != IDLE || !auto_en || cmd_valid || w_auto) begin
         r_idle <= '0;
      end else begin
         r_idle <= r_idle + 1'b1;
      end
   end
`else
   assign w_auto     = 1'b0;
   assign w_auto_idx = '0;
`endif

   assign w_go     = (cmd_valid | w_auto) && (r_state == IDLE);
   assign w_go_op  = cmd_valid ? cmd_op  : OP_SELECT;
   assign w_go_ch  = cmd_valid ? cmd_ch  : '0;
   assign w_go_idx = cmd_valid ? cmd_idx : w_auto_idx;
   assign w_bad    = ({1'b0, w_go_idx} >= NB) ||
                     (w_go_op == OP_SELECT && {1'b0, w_go_ch} >= NC);

   always_comb begin
      w_state_nxt = r_state;
      w_porst_nxt = r_porst;
      w_sel_nxt   = r_sel;
      w_dec_nxt   = r_dec;
      w_sw_nxt    = r_sw;
      w_done_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
      w_load      = 1'b0;
      w_load_val  = '0;
      w_lat       = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_go) begin
               if (w_bad) begin
                  w_err_nxt = 1'b1;
               end else if (w_go_op == OP_SELECT) begin
                  w_state_nxt        = BREAK;
                  w_sw_nxt[w_go_ch]  = 1'b0;
                  w_dec_nxt[w_go_ch] = 1'b0;
                  w_load             = 1'b1;
                  w_load_val         = CW'(BREAK_CYC - 1);
                  w_lat              = 1'b1;
               end else begin
                  w_state_nxt           = PULSE;
                  w_porst_nxt[w_go_idx] = 1'b1;
                  w_load                = 1'b1;
                  w_load_val            = CW'(PORST_CYC - 1);
                  w_lat                 = 1'b1;
               end
            end
         end
         BREAK: begin
            if (w_zero) begin
               w_state_nxt                    = SETTLE;
               w_sel_nxt[r_ch*SEL_W +: SEL_W] = r_idx;
               w_dec_nxt[r_ch]                = 1'b1;
               w_load                         = 1'b1;
               w_load_val                     = CW'(SETTLE_CYC - 1);
            end
         end
         SETTLE: begin
            if (w_zero) begin
               w_state_nxt    = IDLE;
               w_sw_nxt[r_ch] = 1'b1;
               w_done_nxt     = 1'b1;
            end
         end
         PULSE: begin
            if (w_zero) begin
               w_state_nxt = IDLE;
               w_porst_nxt = '0;
               w_done_nxt  = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_ch    <= '0;
         r_idx   <= '0;
         r_porst <= '0;
         r_sel   <= '0;
         r_dec   <= '0;
         r_sw    <= '0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_porst <= w_porst_nxt;
         r_sel   <= w_sel_nxt;
         r_dec   <= w_dec_nxt;
         r_sw    <= w_sw_nxt;
         r_done  <= w_done_nxt;
         r_err   <= w_err_nxt;
         if (w_lat) begin
            r_ch  <= w_go_ch;
            r_idx <= w_go_idx;
         end
      end
   end

   bgr_scan_timer #(
      .W (CW)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_load),
      .i_val  (w_load_val),
      .o_zero (w_zero)
   );

   assign cmd_ready  = (r_state == IDLE);
   assign busy       = (r_state != IDLE);
   assign done       = r_done;
   assign err        = r_err;
   assign porst      = r_porst;
   assign s_sel      = r_sel;
   assign decoder_en = r_dec;
   assign switch_en  = r_sw;

endmodule

// File: tb/tb_bgr_scan_ctrl.sv
// Randomised command bench for bgr_scan_ctrl against a cycle-timeline model.
// Auto-scan checks are included when BGR_SCAN_AUTO_EN is defined.
module tb_bgr_scan_ctrl;

   localparam int N  = 20;
   localparam int NC = 3;
   localparam int B  = 4;
   localparam int S  = 8;
   localparam int P  = 16;
   localparam int D  = 20;
   localparam int SW = $clog2(N);
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_op = 1'b0;
   logic [CW-1:0] cmd_ch = '0;
   logic [SW-1:0] cmd_idx = '0;
   logic          cmd_ready, done, err, busy;
   logic [N-1:0]     porst;
   logic [NC*SW-1:0] s_sel;
   logic [NC-1:0]    decoder_en, switch_en;
`ifdef BGR_SCAN_AUTO_EN
   logic          auto_en = 1'b0;
`endif

   int n_vec = 0;
   int n_bad = 0;

   logic [SW-1:0] m_sel [NC];
   logic [NC-1:0] m_dec, m_sw;

   typedef struct {
      bit op;
      int ch;
      int idx;
      bit chain;
   } cmd_t;
   cmd_t q[$];

   always #5 clk = ~clk;

   bgr_scan_ctrl #(
      .N_BGR      (N),
      .NUM_CH     (NC),
      .BREAK_CYC  (B),
      .SETTLE_CYC (S),
      .PORST_CYC  (P),
      .DWELL_CYC  (D)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_ch     (cmd_ch),
      .cmd_idx    (cmd_idx),
      .done       (done),
      .err        (err),
      .porst      (porst),
      .s_sel      (s_sel),
      .decoder_en (decoder_en),
      .switch_en  (switch_en),
`ifdef BGR_SCAN_AUTO_EN
      .auto_en    (auto_en),
`endif
      .busy       (busy)
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [NC*SW-1:0] pack_sel(input int ch,
                                                 input int v,
                                                 input bit use_new);
      logic [NC*SW-1:0] r;
      for (int c = 0; c < NC; c++)
         r[c*SW +: SW] = (use_new && c == ch) ? SW'(v) : m_sel[c];
      return r;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NC; c++) m_sel[c] = '0;
      m_dec = '0;
      m_sw  = '0;
   endtask

   task automatic drive(input bit op, input int ch, input int idx);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_ch    = CW'(ch);
      cmd_idx   = SW'(idx);
   endtask

   // Caller has the command on the inputs at a negedge; edge k=1 accepts it
   task automatic run(input bit op, input int ch, input int idx,
                      input bit chain, input bit nop, input int nch,
                      input int nidx);
      bit bad;
      int last;
      logic [N-1:0]  ep;
      logic [NC-1:0] ed, es;
      bad  = (idx >= N) || (!op && ch >= NC);
      last = bad ? 1 : (op ? 1 + P : 1 + B + S);
      for (int k = 1; k <= last; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k == 1) begin
            if (chain) drive(nop, nch, nidx);
            else cmd_valid = 1'b0;
         end
         ep = '0;
         ed = m_dec;
         es = m_sw;
         if (!bad && op) begin
            if (k < 1 + P) ep[idx] = 1'b1;
         end else if (!bad) begin
            ed[ch] = (k >= 1 + B);
            es[ch] = (k >= 1 + B + S);
         end
         check("porst", porst, ep);
         check("s_sel", s_sel, pack_sel(ch, idx, !bad && !op && k >= 1 + B));
         check("decoder_en", decoder_en, ed);
         check("switch_en", switch_en, es);
         check("done", done, !bad && k == last);
         check("err", err, bad);
         check("cmd_ready", cmd_ready, bad || k == last);
         check("busy", busy, !bad && k < last);
      end
      if (!bad && !op) begin
         m_sel[ch] = SW'(idx);
         m_dec[ch] = 1'b1;
         m_sw[ch]  = 1'b1;
      end
   endtask

   task automatic go(input bit op, input int ch, input int idx);
      @(negedge clk);
      drive(op, ch, idx);
      run(op, ch, idx, 1'b0, 1'b0, 0, 0);
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "_porst"}, porst, 0);
      check({tag, "_sel"}, s_sel, 0);
      check({tag, "_dec"}, decoder_en, 0);
      check({tag, "_sw"}, switch_en, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_err"}, err, 0);
      check({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int cnt;
      model_reset();
      #12;
      check_idle_zero("rst");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_ready", cmd_ready, 1);
      check_idle_zero("post_rst");

      go(0, 1, 17);
      go(1, 0, N - 1);
      go(0, 0, 31);
      go(1, 0, 25);
      go(0, 3, 4);
      go(0, 1, 17);

      @(negedge clk);
      drive(0, 2, 9);
      run(0, 2, 9, 1'b1, 1'b0, 0, 3);
      run(0, 0, 3, 1'b1, 1'b1, 0, 7);
      run(1, 0, 7, 1'b0, 1'b0, 0, 0);

      for (int i = 0; i < 30; i++) begin
         cmd_t c;
         c.op    = 1'($urandom_range(0, 1));
         c.ch    = int'($urandom_range(0, 3));
         c.idx   = int'($urandom_range(0, 31));
         c.chain = 1'($urandom_range(0, 1));
         q.push_back(c);
      end
      q[q.size()-1].chain = 1'b0;
      for (int i = 0; i < q.size(); i++) begin
         int j;
         j = (i + 1 < q.size()) ? i + 1 : i;
         if (i == 0 || !q[i-1].chain) begin
            @(negedge clk);
            drive(q[i].op, q[i].ch, q[i].idx);
         end
         run(q[i].op, q[i].ch, q[i].idx, q[i].chain,
             q[j].op, q[j].ch, q[j].idx);
         if (!q[i].chain) repeat ($urandom_range(0, 2)) @(negedge clk);
      end

`ifdef BGR_SCAN_AUTO_EN
      go(0, 0, N - 1);
      auto_en = 1'b1;
      cnt = 0;
      while (!busy && cnt < 3 * D) begin
         @(negedge clk);
         cnt++;
      end
      check("auto_dwell", cnt, D);
      check("auto_break", switch_en[0], 0);
      repeat (B + S) @(negedge clk);
      check("auto_wrap", s_sel[SW-1:0], 0);
      check("auto_sw", switch_en[0], 1);
      check("auto_done", done, 1);
      auto_en = 1'b0;
      m_sel[0] = '0;
      m_dec[0] = 1'b1;
      m_sw[0]  = 1'b1;
      @(negedge clk);
      auto_en = 1'b1;
      repeat (D / 2) @(negedge clk);
      drive(1, 0, 3);
      run(1, 0, 3, 1'b0, 1'b0, 0, 0);
      auto_en = 1'b0;
      check("auto_preempt_sel", s_sel[SW-1:0], 0);
`else
      cnt = 0;
`endif

      go(0, 2, 11);
      @(negedge clk);
      drive(1, 0, 5);
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("pulse5", porst, 64'd1 << 5);
      #2;
      rst = 1'b1;
      #1;
      check("async_porst", porst, 0);
      check("async_sw", switch_en, 0);
      check("async_dec", decoder_en, 0);
      check("async_sel", s_sel, 0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      check("rst2_ready", cmd_ready, 1);
      check_idle_zero("rst2");
      go(0, 0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
